regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the write-data width.
REQ-002 The block SHALL have parameter ADDR_W, default 2, giving the register-address width (four registers).
REQ-003 Port clock, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be an asynchronous, active-high reset.
REQ-005 Port stall, input, 1 bit, SHALL block all grants while high.
REQ-006 Ports a_valid (input, 1), a_wr (input, ADDR_W), a_wd (input, DATA_W) SHALL form write request A (ALU writeback).
REQ-007 Port a_ready, output, 1 bit, SHALL indicate request A is accepted this cycle.
REQ-008 Ports b_valid (input, 1), b_wr (input, ADDR_W), b_wd (input, DATA_W) SHALL form write request B (load writeback).
REQ-009 Port b_ready, output, 1 bit, SHALL indicate request B is accepted this cycle.
REQ-010 Port rf_regwrite, output, 1 bit, SHALL be the registered write enable to the register file.
REQ-011 Ports rf_wr (output, ADDR_W) and rf_wd (output, DATA_W) SHALL be the registered write address and data to the register file.
REQ-012 Port pending, output, 2**ADDR_W bits, SHALL flag registers whose write is held in the output stage.
REQ-013 Port write_count, output, 8 bits, SHALL count retired writes to nonzero registers.

Function
REQ-014 A transfer SHALL occur on a rising edge where x_valid and x_ready are both high.
REQ-015 a_ready and b_ready SHALL be combinational from valid, stall and priority pointer, and SHALL never be high simultaneously.
REQ-016 While stall = 1, both ready outputs SHALL be 0.
REQ-017 With stall = 0 and exactly one requester valid, that requester's ready SHALL be 1.
REQ-018 With stall = 0 and both valid, the requester named by the 1-bit round-robin pointer prio (0 = A, 1 = B) SHALL be granted.
REQ-019 prio SHALL invert only after a contended grant (both valid); it SHALL remain unchanged after an uncontended grant or no grant.
REQ-020 On a transfer, the granted requester's wr/wd SHALL be loaded into rf_wr/rf_wd on that edge; rf_regwrite SHALL be 1 for the following cycle only, unless a new transfer follows on the next edge.
REQ-021 A transfer with wr = 0 SHALL be accepted (ready = 1) but SHALL load rf_regwrite = 0, SHALL not change pending, and SHALL not increment write_count.
REQ-022 Without a transfer on an edge, rf_regwrite SHALL load 0; rf_wr and rf_wd SHALL hold their values.
REQ-023 Latency from accepting transfer to rf_regwrite = 1 SHALL be one cycle; the register file commits on the falling edge of that cycle.
REQ-024 Back-to-back transfers SHALL be supported at one per cycle with no bubble.
REQ-025 pending SHALL equal one-hot(rf_wr) when rf_regwrite = 1, else all zeros.
REQ-026 write_count SHALL increment by 1 on each rising edge where rf_regwrite = 1, wrapping 255 -> 0.
REQ-027 Valid inputs SHALL not be required to stay asserted; an unaccepted request carries no state.

Reset
REQ-028 Asserting reset SHALL immediately force rf_regwrite = 0, rf_wr = 0, rf_wd = 0, pending = 0, write_count = 0, prio = 0, independent of clock.
REQ-029 While reset is high, a_ready and b_ready SHALL be 0.
REQ-030 A write in the output stage when reset asserts SHALL be dropped; no write reaches the register file.
REQ-031 After reset deasserts, the first contended grant SHALL go to A.

Verification
REQ-032 Single request: a_valid = 1, a_wr = 1, a_wd = 16'hAAAA, one cycle -> a_ready = 1; next cycle rf_regwrite = 1, rf_wr = 1, rf_wd = 16'hAAAA, pending = 4'b0010; write_count = 1 after.
REQ-033 Contention: A (wr 1, 16'h1111) and B (wr 2, 16'h2222) valid for 4 cycles after reset -> grants A, B, A, B; rf_wd sequence 1111, 2222, 1111, 2222; rf_regwrite high 4 consecutive cycles.
REQ-034 Register 0: b_valid = 1, b_wr = 0, b_wd = 16'h5555 -> b_ready = 1; next cycle rf_regwrite = 0, pending = 0, write_count unchanged.
REQ-035 Stall: both valid with stall = 1 for 3 cycles -> a_ready = b_ready = 0, rf_regwrite = 0, prio unchanged; stall drop -> A granted.
REQ-036 Reset mid-operation: accept A (wr 3, 16'hBEEF), assert reset before next rising edge -> rf_regwrite, pending, write_count drop to 0 at once; no write observed.
REQ-037 Wrap: 256 retired nonzero writes from reset -> write_count = 0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin write arbiter feeding a single registered register-file write port.
// Register 0 writes are accepted but never raise rf_regwrite.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     a_valid,
    input  logic [ADDR_W-1:0]        a_wr,
    input  logic [DATA_W-1:0]        a_wd,
    output logic                     a_ready,
    input  logic                     b_valid,
    input  logic [ADDR_W-1:0]        b_wr,
    input  logic [DATA_W-1:0]        b_wd,
    output logic                     b_ready,
    output logic                     rf_regwrite,
    output logic [ADDR_W-1:0]        rf_wr,
    output logic [DATA_W-1:0]        rf_wd,
    output logic [(2**ADDR_W)-1:0]   pending,
    output logic [7:0]               write_count
);

    logic               prio_q, prio_d;
    logic               rf_regwrite_q, rf_regwrite_d;
    logic [ADDR_W-1:0]  rf_wr_q, rf_wr_d;
    logic [DATA_W-1:0]  rf_wd_q, rf_wd_d;
    logic [7:0]         write_count_q, write_count_d;

    logic               contended;
    logic               xfer;
    logic [ADDR_W-1:0]  sel_wr;
    logic [DATA_W-1:0]  sel_wd;

    assign contended = a_valid && b_valid;

    // prio = 0 favours A, 1 favours B; it only matters when both are valid.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!reset && !stall) begin
            a_ready = a_valid && (!b_valid || !prio_q);
            b_ready = b_valid && (!a_valid || prio_q);
        end
    end

    assign xfer   = a_ready || b_ready;
    assign sel_wr = b_ready ? b_wr : a_wr;
    assign sel_wd = b_ready ? b_wd : a_wd;

    always_comb begin
        prio_d        = prio_q;
        rf_regwrite_d = 1'b0;
        rf_wr_d       = rf_wr_q;
        rf_wd_d       = rf_wd_q;
        write_count_d = write_count_q;
        if (xfer) begin
            rf_regwrite_d = (sel_wr != '0);
            rf_wr_d       = sel_wr;
            rf_wd_d       = sel_wd;
            if (contended) begin
                prio_d = ~prio_q;
            end
        end
        if (rf_regwrite_q) begin
            write_count_d = write_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_q        <= 1'b0;
            rf_regwrite_q <= 1'b0;
            rf_wr_q       <= '0;
            rf_wd_q       <= '0;
            write_count_q <= 8'd0;
        end else begin
            prio_q        <= prio_d;
            rf_regwrite_q <= rf_regwrite_d;
            rf_wr_q       <= rf_wr_d;
            rf_wd_q       <= rf_wd_d;
            write_count_q <= write_count_d;
        end
    end

    always_comb begin
        pending = '0;
        if (rf_regwrite_q) begin
            pending[rf_wr_q] = 1'b1;
        end
    end

    assign rf_regwrite = rf_regwrite_q;
    assign rf_wr       = rf_wr_q;
    assign rf_wd       = rf_wd_q;
    assign write_count = write_count_q;

endmodule
